// File: rtl/fxadd_rr_if.sv
// Request/result bundle for fxadd_rr_scheduler: NREQ operand-pair request
// channels and one result channel, each with a valid/ready handshake.
interface fxadd_rr_if #(
    parameter int unsigned WI   = 4,
    parameter int unsigned WF   = 4,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned W   = WI + WF;
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/fxadd_rr_scheduler.sv
// Round-robin scheduler feeding a two-stage signed fixed-point (WI.WF) adder.
// Optional macro FXADD_RR_SAT_EN: saturate overflowed sums instead of wrapping.
module fxadd_rr_scheduler #(
    parameter int unsigned WI   = 4,
    parameter int unsigned WF   = 4,
    parameter int unsigned NREQ = 4
) (
    input  logic       clk,
    input  logic       reset,
    fxadd_rr_if.slave  bus
);
    localparam int unsigned W   = WI + WF;
    localparam int unsigned IDW = $clog2(NREQ);

    logic             en_c;
    logic [NREQ-1:0]  grant_c;
    logic [IDW-1:0]   grant_id_c;
    logic             grant_any_c;
    logic [IDW-1:0]   pick_c;
    logic [IDW-1:0]   last_grant;

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [IDW-1:0]   s1_id;

    logic [W:0]       sum_c;
    logic             ovf_c;
    logic [W-1:0]     data_c;

    // The pipeline moves only when the result slot is empty or being taken.
    assign en_c          = !bus.res_valid || bus.res_ready;
    assign bus.req_ready = grant_c;

    // Round-robin pick: scan from last_grant+1, first valid requester wins.
    always_comb begin
        grant_c     = '0;
        grant_id_c  = '0;
        grant_any_c = 1'b0;
        pick_c      = '0;
        if (!reset && en_c) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                pick_c = IDW'((32'(last_grant) + k) % NREQ);
                if (!grant_any_c && bus.req_valid[pick_c]) begin
                    grant_any_c     = 1'b1;
                    grant_id_c      = pick_c;
                    grant_c[pick_c] = 1'b1;
                end
            end
        end
    end

    // Stage 1: capture the granted operand pair and its requester ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (en_c) begin
            s1_valid <= grant_any_c;
            if (grant_any_c) begin
                s1_a       <= bus.req_a[32'(grant_id_c) * W +: W];
                s1_b       <= bus.req_b[32'(grant_id_c) * W +: W];
                s1_id      <= grant_id_c;
                last_grant <= grant_id_c;
            end
        end
    end

    // Exact sum with one guard bit; overflow when guard and sign disagree.
    always_comb begin
        sum_c  = {s1_a[W-1], s1_a} + {s1_b[W-1], s1_b};
        ovf_c  = sum_c[W] ^ sum_c[W-1];
        data_c = sum_c[W-1:0];
`ifdef FXADD_RR_SAT_EN
        if (ovf_c) begin
            data_c = sum_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            bus.res_ovf   <= 1'b0;
        end else if (en_c) begin
            bus.res_valid <= s1_valid;
            bus.res_data  <= data_c;
            bus.res_id    <= s1_id;
            bus.res_ovf   <= ovf_c;
        end
    end
endmodule

// File: tb/tb_fxadd_rr_scheduler.sv
// Scoreboard bench for fxadd_rr_scheduler: a round-robin reference issues
// expected results into a queue, an independent monitor pops and compares.
module tb_fxadd_rr_scheduler;
    localparam int unsigned WI   = 4;
    localparam int unsigned WF   = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = WI + WF;
    localparam int unsigned IDW  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           ovf;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [W-1:0] va [NREQ];
    logic [W-1:0] vb [NREQ];
    logic [W-1:0] ve [NREQ];
    logic         vo [NREQ];
    exp_t         sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxadd_rr_if #(.WI(WI), .WF(WF), .NREQ(NREQ)) bus ();

    fxadd_rr_scheduler #(.WI(WI), .WF(WF), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pack per-requester operand tables onto the bus.
    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = va[i];
            bus.req_b[i*W +: W] = vb[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Load requester i with operands and its hand-computed result.
    task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e_wrap, input logic [W-1:0] e_sat,
                           input logic ovf);
        va[i] = a;
        vb[i] = b;
`ifdef FXADD_RR_SAT_EN
        ve[i] = e_sat;
`else
        ve[i] = e_wrap;
`endif
        vo[i] = ovf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: checks req_ready and issues expected results.
    logic [IDW-1:0] m_lg;
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic            en_m;
        int              idx;
        exp_t            e;
        exp_rdy = '0;
        if (reset) begin
            m_lg = IDW'(NREQ - 1);
            sbq.delete();
        end else begin
            en_m = !bus.res_valid || bus.res_ready;
            if (en_m) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (int'(m_lg) + k) % NREQ;
                    if (exp_rdy == '0 && bus.req_valid[idx]) exp_rdy[idx] = 1'b1;
                end
            end
        end
        checks++;
        if (bus.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
        end
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && exp_rdy[i]) begin
                    e.id   = IDW'(i);
                    e.data = ve[i];
                    e.ovf  = vo[i];
                    e.cyc  = cyc;
                    sbq.push_back(e);
                    m_lg = IDW'(i);
                end
            end
        end
    end

    // Result monitor: order/value/latency on consume, stability while stalled.
    logic           held = 1'b0;
    logic [W-1:0]   h_data;
    logic [IDW-1:0] h_id;
    logic           h_ovf;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!bus.res_valid || bus.res_data !== h_data || bus.res_id !== h_id ||
                    bus.res_ovf !== h_ovf) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got v=%b d=%h id=%0d o=%b exp v=1 d=%h id=%0d o=%b",
                             cyc, bus.res_valid, bus.res_data, bus.res_id, bus.res_ovf,
                             h_data, h_id, h_ovf);
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                held = 1'b0;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result cyc=%0d got id=%0d d=%h exp none",
                             cyc, bus.res_id, bus.res_data);
                end else begin
                    e = sbq.pop_front();
                    if (bus.res_id !== e.id || bus.res_data !== e.data ||
                        bus.res_ovf !== e.ovf || (cyc - e.cyc) < 2) begin
                        errors++;
                        $display("FAIL result cyc=%0d got id=%0d d=%h o=%b lat=%0d exp id=%0d d=%h o=%b lat>=2",
                                 cyc, bus.res_id, bus.res_data, bus.res_ovf, cyc - e.cyc,
                                 e.id, e.data, e.ovf);
                    end
                end
            end else if (bus.res_valid) begin
                held   = 1'b1;
                h_data = bus.res_data;
                h_id   = bus.res_id;
                h_ovf  = bus.res_ovf;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        int   lat;
        logic got;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_vec(i, '0, '0, '0, '0, 1'b0);
        repeat (3) tick();

        // Reset values.
        @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'(0));
        chk("rst_res_data",  32'(bus.res_data),  32'(0));
        chk("rst_res_id",    32'(bus.res_id),    32'(0));
        chk("rst_res_ovf",   32'(bus.res_ovf),   32'(0));
        tick();
        reset = 1'b0;

        // 1.5 + 0.5 from requester 0; result two cycles after the transfer.
        set_vec(0, 8'h18, 8'h08, 8'h20, 8'h20, 1'b0);
        bus.req_valid = 4'b0001;
        @(posedge clk);
        #1 bus.req_valid = '0;
        lat = 1;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (bus.res_valid) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("first_latency", got ? 32'(lat) : 32'hdead, 32'(2));
        chk("first_data",    32'(bus.res_data), 32'h20);
        tick();

        // Lone requester is granted back to back.
        set_vec(2, 8'h10, 8'h01, 8'h11, 8'h11, 1'b0);
        bus.req_valid = 4'b0100;
        repeat (4) tick();

        // All four contending: rotation and overflow cases.
        set_vec(0, 8'h18, 8'h08, 8'h20, 8'h20, 1'b0);
        set_vec(1, 8'h70, 8'h20, 8'h90, 8'h7F, 1'b1);
        set_vec(2, 8'h80, 8'h80, 8'h00, 8'h80, 1'b1);
        set_vec(3, 8'hF8, 8'h04, 8'hFC, 8'hFC, 1'b0);
        bus.req_valid = 4'b1111;
        repeat (8) tick();

        // Consumer stall with results in flight.
        set_vec(3, 8'h7F, 8'h01, 8'h80, 8'h7F, 1'b1);
        set_vec(0, 8'hC0, 8'hE0, 8'hA0, 8'hA0, 1'b0);
        repeat (2) tick();
        bus.res_ready = 1'b0;
        repeat (3) tick();
        bus.res_ready = 1'b1;
        repeat (4) tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Reset with two operations in flight.
        bus.req_valid = 4'b1111;
        repeat (2) tick();
        reset         = 1'b1;
        bus.req_valid = '0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_res_valid", 32'(bus.res_valid), 32'(0));
        tick();
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("post_reset_first_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        repeat (4) tick();
        bus.req_valid = '0;
        repeat (5) tick();

        @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fxadd_rr_scheduler.md
FXADD_RR_SCHEDULER -- requirements
Module: fxadd_rr_scheduler

Interface
REQ-001 Parameter WI, default 4: integer bits of every operand and of the result, sign included.
REQ-002 Parameter WF, default 4: fraction bits of every operand and of the result.
REQ-003 Parameter NREQ, default 4: number of requesters, range 2..8; IDW = clog2(NREQ).
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 req_a  input  NREQ*(WI+WF)  packed signed operand A; slice i belongs to requester i.
REQ-008 req_b  input  NREQ*(WI+WF)  packed signed operand B; slice i belongs to requester i.
REQ-009 req_ready  output  NREQ  one-hot-or-zero grant; transfer for requester i when req_valid[i] and req_ready[i] are both high.
REQ-010 res_valid  output  1  result valid.
REQ-011 res_ready  input  1  result consumer ready.
REQ-012 res_data  output  WI+WF  signed sum A+B in the WI.WF format.
REQ-013 res_id  output  IDW  index of the requester that issued the result.
REQ-014 res_ovf  output  1  the exact sum did not fit in WI+WF bits.

Function
REQ-015 Each cycle there SHALL be at most one grant: at most one req_ready bit high.
REQ-016 Pipeline advance en SHALL be (!res_valid | res_ready); when en=0, req_ready SHALL be all zero and no pipeline register SHALL change.
REQ-017 The arbiter SHALL be round-robin: search starts at last_grant+1 modulo NREQ and grants the first requester with valid set; last_grant updates only on a transfer.
REQ-018 req_ready SHALL depend combinationally on req_valid, last_grant and en only, with no dependence on req_a or req_b.
REQ-019 Stage 1: on transfer, the operands, the requester ID and a stage-1 valid bit SHALL be registered; with no transfer and en=1, the stage-1 valid bit SHALL clear.
REQ-020 Stage 2: the full-width sum SHALL be computed with WI+WF+1 bits, sign-extended, and registered into res_data, res_id, res_ovf and res_valid when en=1.
REQ-021 Latency: a transfer in cycle T SHALL present its result with res_valid high from cycle T+2, held stable until res_ready is sampled high.
REQ-022 Throughput SHALL be one operation per cycle while res_ready stays high.
REQ-023 res_ovf SHALL be high when bit WI+WF of the full sum differs from bit WI+WF-1.
REQ-024 Results SHALL leave in issue order; no result SHALL be dropped or duplicated under any res_ready pattern.
REQ-025 A requester deasserting req_valid without a transfer SHALL lose its turn without error; the pointer does not move.
REQ-026 If only one requester is valid, it SHALL be granted every cycle while en=1.

Reset
REQ-027 While reset is high at a clock edge: res_valid=0, res_data=0, res_id=0, res_ovf=0, stage-1 valid=0, last_grant=NREQ-1 (so requester 0 is searched first).
REQ-028 req_ready SHALL be all zero during any cycle in which reset is high.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations without producing a result.

Configuration
REQ-030 Macro FXADD_RR_SAT_EN: when defined, an overflowed result SHALL saturate res_data to the maximum positive value (0 followed by all 1s) or the minimum negative value (1 followed by all 0s) according to the true sum's sign, and res_ovf still flags it.
REQ-031 Without FXADD_RR_SAT_EN, res_data SHALL be the low WI+WF bits of the sum (wrap) and res_ovf still flags it.

Verification
REQ-032 Reset, then requester 0 only, A=0x18 (1.5), B=0x08 (0.5), res_ready=1 -> res_valid two cycles later, res_data=0x20, res_id=0, res_ovf=0.
REQ-033 All four valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; res_id follows the same sequence two cycles later.
REQ-034 A=0x70, B=0x20 (7.0+2.0) -> res_ovf=1; res_data=0x90 without the macro, 0x7F with FXADD_RR_SAT_EN.
REQ-035 res_ready held low for 3 cycles with results in flight -> req_ready=0, res_data/res_id stable, and after release no loss or reorder.
REQ-036 Reset asserted while 2 operations are in flight -> res_valid=0 next cycle, and the first grant after reset goes to requester 0.
REQ-037 A=0x80, B=0x80 (-8+-8) -> res_ovf=1; res_data=0x00 wrap, 0x80 with saturation.
